mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
// - Multiply/divide unit beside the integer ALU in the execute stage; takes rs/rt operand data from the GRF read ports.
// - Owns the HI/LO registers, which mfhi/mflo select onto the register write-back mux.
// - Models real latency with a busy counter: mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES.
// - Controller stalls any MDU-class instruction while Busy is high.
// PARAMETERS
// - MULT_CYCLES  5   cycles Busy stays high after a mult/multu start (>=1)
// - DIV_CYCLES   10  cycles Busy stays high after a div/divu start (>=1)
// PORTS
// - clk      in   1   system clock, rising edge
// - reset    in   1   synchronous, active-high; clears all state
// - Start    in   1   MDUOp valid this cycle
// - MDUOp    in   3   operation code (see package)
// - SrcA     in   32  operand A (GRF rs data)
// - SrcB     in   32  operand B (GRF rt data)
// - Busy     out  1   operation in flight; registered output
// - HI       out  32  architectural HI register
// - LO       out  32  architectural LO register
// BEHAVIOUR
// - One clock (clk). Reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
// - Reset values: Busy=0, HI=0, LO=0, counter=0, pending result=0, state IDLE.
// - FSM: IDLE, RUN.
//   - IDLE + Start + MULT/MULTU/DIV/DIVU: latch the computed {hi,lo} into a pending register.
//     Load counter with MULT_CYCLES or DIV_CYCLES, set Busy=1, go to RUN.
//   - RUN: decrement counter every cycle. At the edge where the counter goes 1->0, write pending to HI/LO, set Busy=0, return to IDLE.
//   - Timing: Start sampled at edge t. Busy is high for cycles t+1..t+N. New HI/LO are visible and Busy=0 from edge t+N.
//   - HI/LO hold their old values throughout RUN; mfhi during RUN is stalled by the controller.
// - MTHI/MTLO: IDLE only. HI<=SrcA (or LO<=SrcA) at the sampling edge; Busy stays 0; zero latency.
// - Start while Busy=1 (any op): ignored entirely; state, counter and HI/LO are unchanged.
// - Start with MDU_NONE or an undefined code: no effect.
// - Arithmetic:
//   - MULT: {HI,LO} = $signed(A)*$signed(B), 64-bit.
//   - MULTU: unsigned 64-bit product.
//   - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
//   - DIVU: unsigned quotient/remainder.
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
// - Divide by zero (DIV/DIVU with B=0): full DIV_CYCLES busy period still runs; HI/LO are left unchanged at completion.
// - Reset during RUN: operation is aborted; no HI/LO write; all state returns to reset values at that edge.
// - reset has priority over Start at the same edge.
// STRUCTURE
// - Shared package mdu_pkg:
//   - MDUOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; 7 reserved.
//   - State encoding IDLE/RUN.
// - The controller uses mdu_pkg to decode mult/div/mthi/mtlo/mfhi/mflo and to generate the stall.
// - One combinational sub-module, mdu_calc (op, A, B -> hi, lo, div_by_zero). It isolates the arithmetic so it can be checked standalone.
// - Counter, FSM and HI/LO registers live in mdu_unit.
// TESTING
// - Reset, then MULT A=0xFFFFFFFE(-2) B=3: Busy is 1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
// - MULTU A=0xFFFFFFFF B=0xFFFFFFFF: after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
// - DIV A=-7 B=2: Busy is 1 for 10 cycles; then LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1).
//   DIVU A=7 B=2: LO=3, HI=1.
// - MTHI 0x12345678, then a MULT with Start pulsed again at cycles 2 and 3 of Busy:
//   - MTHI: HI=0x12345678 next edge, Busy stays 0.
//   - MULT: extra Starts are ignored; exactly one 5-cycle Busy window.
// - DIVU B=0 with HI=LO=0xAAAA5555: 10 busy cycles; HI/LO remain 0xAAAA5555.
// - DIV started, reset asserted at busy cycle 4: next edge Busy=0, HI=LO=0; no later write occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU operation and state encodings
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic signed [31:0] squot;
    logic signed [31:0] srem;
    logic        [31:0] ub;
    logic        [31:0] uquot;
    logic        [31:0] urem;
    logic               b_zero;
    logic               s_overflow;

    assign b_zero     = (b == 32'd0);
    // Divisor forced to 1 on zero so the dividers never see an undefined case.
    assign ub         = b_zero ? 32'd1 : b;
    assign sa         = $signed(a);
    assign sb         = $signed(ub);
    assign s_overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};
    assign squot = s_overflow ? 32'sh8000_0000 : sa / sb;
    assign srem  = s_overflow ? 32'sd0 : sa % sb;
    assign uquot = a / ub;
    assign urem  = a % ub;

    always_comb begin
        hi          = 32'd0;
        lo          = 32'd0;
        div_by_zero = 1'b0;
        case (mdu_op_e'(op))
            MDU_MULT:  {hi, lo} = sprod;
            MDU_MULTU: {hi, lo} = uprod;
            MDU_DIV: begin
                hi          = srem;
                lo          = squot;
                div_by_zero = b_zero;
            end
            MDU_DIVU: begin
                hi          = urem;
                lo          = uquot;
                div_by_zero = b_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multiply/divide unit with HI/LO and busy-latency model
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    mdu_state_e         state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic [63:0]        pending;
    logic               pending_dbz;
    logic               busy_q;
    logic [31:0]        calc_hi, calc_lo;
    logic               calc_dbz;
    logic               load, finish, wr_hi, wr_lo;

    mdu_calc u_calc (
        .op          (MDUOp),
        .a           (SrcA),
        .b           (SrcB),
        .hi          (calc_hi),
        .lo          (calc_lo),
        .div_by_zero (calc_dbz)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pending     <= '0;
            pending_dbz <= 1'b0;
            busy_q      <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == ST_RUN);
            if (load) begin
                pending     <= {calc_hi, calc_lo};
                pending_dbz <= calc_dbz;
                cnt         <= is_div_op(MDUOp) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            end else if (state == ST_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            // A divide by zero still runs its full latency but never commits.
            if (finish && !pending_dbz) begin
                HI <= pending[63:32];
                LO <= pending[31:0];
            end
            if (wr_hi) HI <= SrcA;
            if (wr_lo) LO <= SrcA;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (Start && is_long_op(MDUOp)) state_next = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(1)) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load   = (state == ST_IDLE) && Start && is_long_op(MDUOp);
        finish = (state == ST_RUN) && (cnt == CNT_W'(1));
        wr_hi  = (state == ST_IDLE) && Start && (MDUOp == MDU_MTHI);
        wr_lo  = (state == ST_IDLE) && Start && (MDUOp == MDU_MTLO);
        Busy   = busy_q;
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - directed self-checking bench for mdu_unit
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk = ~clk;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .Start (Start),
        .MDUOp (MDUOp),
        .SrcA  (SrcA),
        .SrcB  (SrcB),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        SrcA  = a;
        SrcB  = b;
        step();
        Start = 1'b0;
        MDUOp = 3'd0;
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (Busy && cycles < 50) begin
            cycles++;
            step();
        end
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        MDUOp = 3'd0;
        SrcA  = '0;
        SrcB  = '0;
        step();
        step();
        reset = 1'b0;
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hold_hi", HI, 32'd0);
        count_busy(n);
        check("mult_busy_len", n, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        count_busy(n);
        check("multu_busy_len", n, 32'd5);
        check("multu_hi", HI, 32'hFFFF_FFFE);
        check("multu_lo", LO, 32'h0000_0001);

        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        check("div_busy_len", n, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        issue(3'd4, 32'd7, 32'd2);
        count_busy(n);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'd0);

        issue(3'd5, 32'h1234_5678, 32'd0);
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_busy", {31'd0, Busy}, 32'd0);
        check("mthi_lo_kept", LO, 32'h8000_0000);

        // Extra Starts (a DIVU) during busy cycles 2 and 3 must be dropped.
        issue(3'd1, 32'd3, 32'd4);
        n = 0;
        while (Busy && n < 50) begin
            Start = (n == 1 || n == 2);
            MDUOp = 3'd4;
            SrcA  = 32'd100;
            SrcB  = 32'd7;
            step();
            n++;
        end
        Start = 1'b0;
        check("mult_restart_len", n, 32'd5);
        check("mult_restart_hi", HI, 32'd0);
        check("mult_restart_lo", LO, 32'd12);

        issue(3'd5, 32'hAAAA_5555, 32'd0);
        issue(3'd6, 32'hAAAA_5555, 32'd0);
        issue(3'd4, 32'd5, 32'd0);
        count_busy(n);
        check("dbz_busy_len", n, 32'd10);
        check("dbz_hi", HI, 32'hAAAA_5555);
        check("dbz_lo", LO, 32'hAAAA_5555);

        issue(3'd7, 32'h0BAD_0BAD, 32'd1);
        check("rsvd_busy", {31'd0, Busy}, 32'd0);
        check("rsvd_hi", HI, 32'hAAAA_5555);

        issue(3'd3, 32'd100, 32'd7);
        check("abort_busy_c1", {31'd0, Busy}, 32'd1);
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        repeat (15) step();
        check("abort_late_hi", HI, 32'd0);
        check("abort_late_lo", LO, 32'd0);
        check("abort_late_busy", {31'd0, Busy}, 32'd0);

        reset = 1'b1;
        issue(3'd5, 32'hDEAD_BEEF, 32'd0);
        reset = 1'b0;
        check("reset_prio_hi", HI, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
